// File: rtl/pf_ram_pkg.sv
// Shared types and helpers for the dual-port playfield RAM.
// Video read latency is clamped to the legal range given here.
package pf_ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  localparam int VID_LAT_MIN = 1;
  localparam int VID_LAT_MAX = 2;

  // Even parity over a zero-extended word; the extra zero bits do not change the result.
  function automatic logic parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/pf_clear_seq.sv
// Post-reset clear sequencer: walks every implemented address once, then parks in RUN.
// A reset arriving part-way through restarts the walk at address 0.
module pf_clear_seq
  import pf_ram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          busy_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // No array write on a reset edge, so a restarted clear never touches stale addresses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    clr_we_o   = 1'b0;
    busy_o     = 1'b0;
    clr_addr_o = addr_q;
    case (state_q)
      ST_CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = ~reset;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/pf_ram_dp.sv
// Dual-port playfield RAM: synchronous CPU read/write port plus pipelined video read port.
// Optional feature macro PF_RAM_PARITY_EN adds a stored parity bit checked on video reads.
module pf_ram_dp
  import pf_ram_pkg::*;
#(
  parameter int          DW        = 8,
  parameter int          AW        = 8,
  parameter int          DEPTH     = 256,
  parameter logic [DW-1:0] CLEAR_VAL = '0,
  parameter int          VID_LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_ce_n,
  input  logic          cpu_we_n,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_rdy,
  input  logic [AW-1:0] vid_a,
  input  logic          vid_rd,
  output logic [DW-1:0] vid_dout,
  output logic          vid_valid,
  output logic          clr_busy,
  output logic          par_err
);

`ifdef PF_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  localparam logic [AW:0] DEPTH_W    = (AW + 1)'(DEPTH);
  localparam int          VID_STAGES = (VID_LAT >= VID_LAT_MAX) ? VID_LAT_MAX : VID_LAT_MIN;

  logic [MW-1:0] mem [DEPTH];

  logic          clr_we, busy;
  logic [AW-1:0] clr_addr;
  logic          cpu_in_rng, vid_in_rng, cpu_wr, cpu_rd, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_word, vid_word;
  logic          vid_perr_d;
  logic [DW-1:0] cpu_dout_q;
  logic          v1_valid_q, v1_perr_q;
  logic [DW-1:0] v1_data_q;

  pf_clear_seq #(.AW(AW), .DEPTH(DEPTH)) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );

  assign clr_busy   = busy;
  assign cpu_rdy    = ~busy;
  assign cpu_in_rng = {1'b0, cpu_a} < DEPTH_W;
  assign vid_in_rng = {1'b0, vid_a} < DEPTH_W;
  assign cpu_wr     = cpu_rdy & ~reset & ~cpu_ce_n & ~cpu_we_n & cpu_in_rng;
  assign cpu_rd     = cpu_rdy & ~reset & ~cpu_ce_n & cpu_we_n;

  // Clear and CPU writes never overlap: the CPU port only opens once the clear has finished.
  assign wr_en   = clr_we | cpu_wr;
  assign wr_addr = clr_we ? clr_addr : cpu_a;
  assign wr_data = clr_we ? CLEAR_VAL : cpu_din;
`ifdef PF_RAM_PARITY_EN
  assign wr_word = {parity(64'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout_q <= '0;
    end else if (cpu_rd) begin
      cpu_dout_q <= cpu_in_rng ? mem[cpu_a][DW-1:0] : '0;
    end
  end
  assign cpu_dout = cpu_dout_q;

  // Same-cycle CPU write to the video address forwards the new word (write-first).
  always_comb begin
    vid_word = '0;
    if (vid_in_rng) begin
      vid_word = (cpu_wr && (cpu_a == vid_a)) ? wr_word : mem[vid_a];
    end
  end

`ifdef PF_RAM_PARITY_EN
  assign vid_perr_d = vid_rd & (parity(64'(vid_word[DW-1:0])) != vid_word[DW]);
`else
  assign vid_perr_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_valid_q <= 1'b0;
      v1_perr_q  <= 1'b0;
      v1_data_q  <= '0;
    end else begin
      v1_valid_q <= vid_rd;
      v1_perr_q  <= vid_perr_d;
      if (vid_rd) begin
        v1_data_q <= vid_word[DW-1:0];
      end
    end
  end

  if (VID_STAGES == VID_LAT_MAX) begin : g_vid_lat2
    logic          v2_valid_q, v2_perr_q;
    logic [DW-1:0] v2_data_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_valid_q <= 1'b0;
        v2_perr_q  <= 1'b0;
        v2_data_q  <= '0;
      end else begin
        v2_valid_q <= v1_valid_q;
        v2_perr_q  <= v1_perr_q;
        if (v1_valid_q) begin
          v2_data_q <= v1_data_q;
        end
      end
    end

    assign vid_valid = v2_valid_q;
    assign vid_dout  = v2_data_q;
    assign par_err   = v2_perr_q;
  end else begin : g_vid_lat1
    assign vid_valid = v1_valid_q;
    assign vid_dout  = v1_data_q;
    assign par_err   = v1_perr_q;
  end

endmodule

// File: tb/tb_pf_ram_dp.sv
// Self-checking bench for pf_ram_dp: directed scenarios plus random traffic against a word-array model.
// Parity injection scenario is only built when PF_RAM_PARITY_EN is defined.
module tb_pf_ram_dp;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 240;
  localparam int VID_LAT = 2;
  localparam logic [DW-1:0] CLEAR_VAL = 8'hC3;

  logic          clk;
  logic          reset;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_din;
  logic          cpu_ce_n;
  logic          cpu_we_n;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rdy;
  logic [AW-1:0] vid_a;
  logic          vid_rd;
  logic [DW-1:0] vid_dout;
  logic          vid_valid;
  logic          clr_busy;
  logic          par_err;

  pf_ram_dp #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_VAL(CLEAR_VAL), .VID_LAT(VID_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_a     (cpu_a),
    .cpu_din   (cpu_din),
    .cpu_ce_n  (cpu_ce_n),
    .cpu_we_n  (cpu_we_n),
    .cpu_dout  (cpu_dout),
    .cpu_rdy   (cpu_rdy),
    .vid_a     (vid_a),
    .vid_rd    (vid_rd),
    .vid_dout  (vid_dout),
    .vid_valid (vid_valid),
    .clr_busy  (clr_busy),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             valid;
    logic [DW-1:0]  data;
    bit             perr;
  } vidEntry_t;

  logic [DW-1:0] refMem [DEPTH];
  bit            refPerr [DEPTH];
  bit            inClear;
  int            clrIdx;
  logic [DW-1:0] expCpuDout;
  vidEntry_t     vidQ [$];
  bit            lastWasReset;

  int compareCount = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs held across that edge.
  task automatic modelEdge();
    vidEntry_t e;
    bit        rdy, cpuWrite;
    lastWasReset = reset;
    if (reset) begin
      inClear    = 1'b1;
      clrIdx     = 0;
      expCpuDout = '0;
      vidQ.delete();
      e.valid = 1'b0; e.data = '0; e.perr = 1'b0;
      for (int i = 0; i < VID_LAT; i++) vidQ.push_back(e);
    end else begin
      rdy      = !inClear;
      cpuWrite = rdy && !cpu_ce_n && !cpu_we_n && (int'(cpu_a) < DEPTH);
      e.valid = vid_rd; e.data = '0; e.perr = 1'b0;
      if (vid_rd && int'(vid_a) < DEPTH) begin
        if (cpuWrite && cpu_a == vid_a) begin
          e.data = cpu_din;
        end else begin
          e.data = refMem[vid_a];
          e.perr = refPerr[vid_a];
        end
      end
      vidQ.push_back(e);
      void'(vidQ.pop_front());
      if (rdy && !cpu_ce_n) begin
        if (!cpu_we_n) begin
          if (cpuWrite) begin
            refMem[cpu_a]  = cpu_din;
            refPerr[cpu_a] = 1'b0;
          end
        end else begin
          expCpuDout = (int'(cpu_a) < DEPTH) ? refMem[cpu_a] : '0;
        end
      end
      if (inClear) begin
        refMem[clrIdx]  = CLEAR_VAL;
        refPerr[clrIdx] = 1'b0;
        clrIdx++;
        if (clrIdx == DEPTH) inClear = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ceN, input bit weN, input logic [AW-1:0] a,
                               input logic [DW-1:0] din, input bit vrd, input logic [AW-1:0] va);
    @(negedge clk);
    reset    = rst;
    cpu_ce_n = ceN;
    cpu_we_n = weN;
    cpu_a    = a;
    cpu_din  = din;
    vid_rd   = vrd;
    vid_a    = va;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("cpuRdy", cpu_rdy, !inClear);
    checkOutput("clrBusy", clr_busy, inClear);
    checkOutput("cpuDout", cpu_dout, expCpuDout);
    checkOutput("vidValid", vid_valid, vidQ[0].valid);
    if (vidQ[0].valid || lastWasReset) checkOutput("vidDout", vid_dout, vidQ[0].data);
    checkOutput("parErr", par_err, vidQ[0].perr);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0, '0);
  endtask

  // Steps through a clear and measures how many sampled cycles showed clr_busy.
  task automatic runClear(input string tag, input bit pokeCpu);
    int busyCycles;
    busyCycles = (clr_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < DEPTH + 10 && clr_busy === 1'b1; i++) begin
      if (pokeCpu) applyStimulus(1'b0, 1'b0, 1'b0, 8'h50, 8'h77, 1'b0, '0);
      else         idle();
      if (clr_busy === 1'b1) busyCycles++;
    end
    checkOutput(tag, busyCycles, DEPTH);
    checkOutput({tag, "Rdy"}, cpu_rdy, 1'b1);
  endtask

  initial begin
    reset = 1'b0; cpu_a = '0; cpu_din = '0; cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
    vid_a = '0; vid_rd = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin refMem[i] = 'x; refPerr[i] = 1'b0; end

    // Reset for one cycle, then the full clear.
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0);
    checkOutput("rstCpuDout", cpu_dout, 8'h00);
    checkOutput("rstVidValid", vid_valid, 1'b0);
    runClear("clrLen", 1'b0);

    // Every word reads back the clear value on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, AW'(i), '0, 1'b1, AW'(i));
      checkOutput("clrWord", cpu_dout, CLEAR_VAL);
    end

    // CPU write then read, data held across idle cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, '0, 1'b0, '0);
    checkOutput("t2Read", cpu_dout, 8'hA5);
    for (int i = 0; i < 3; i++) idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, '0);
    checkOutput("t2Hold", cpu_dout, 8'hA5);

    // Write-first collision between CPU write and video read.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'h5A, 1'b1, 8'h10);
    for (int i = 1; i < VID_LAT; i++) idle();
    checkOutput("t3Valid", vid_valid, 1'b1);
    checkOutput("t3Data", vid_dout, 8'h5A);

    // Back-to-back video reads come out in order, VID_LAT cycles later.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, AW'(i), DW'(8'h11 * (i + 1)), 1'b0, '0);
    for (int i = 0; i < 4 + VID_LAT; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, i < 4, AW'(i));
      if (i >= VID_LAT - 1 && i - (VID_LAT - 1) < 4) begin
        checkOutput("t4Valid", vid_valid, 1'b1);
        checkOutput("t4Data", vid_dout, 8'h11 * (i - (VID_LAT - 1) + 1));
      end
    end

    // Out-of-range addresses: writes dropped, reads return zero.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hF5, 8'h99, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF5, '0, 1'b1, 8'hF8);
    checkOutput("oorCpu", cpu_dout, 8'h00);
    for (int i = 1; i < VID_LAT; i++) idle();
    checkOutput("oorVidValid", vid_valid, 1'b1);
    checkOutput("oorVidData", vid_dout, 8'h00);

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] ca, va;
      ca = AW'($urandom_range(0, 255));
      va = ($urandom_range(0, 3) == 0) ? ca : AW'($urandom_range(0, 255));
      applyStimulus(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, ca,
                    DW'($urandom), $urandom_range(0, 1) == 1, va);
    end

    // Reset part-way through a clear restarts it; CPU writes during clear are dropped.
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0);
    for (int i = 1; i < 100; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, AW'($urandom_range(0, 255)), DW'($urandom), 1'b1, AW'(i));
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0);
    runClear("restartLen", 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h50, '0, 1'b0, '0);
    checkOutput("t5Dropped", cpu_dout, CLEAR_VAL);

`ifdef PF_RAM_PARITY_EN
    // Corrupt a stored parity bit and expect the video port to flag it.
    @(negedge clk);
    dut.mem[8'h20][DW] = ~dut.mem[8'h20][DW];
    refPerr[8'h20] = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b1, 8'h20);
    for (int i = 1; i < VID_LAT; i++) idle();
    checkOutput("t6ParErr", par_err, 1'b1);
    checkOutput("t6Valid", vid_valid, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b1, 8'h21);
    for (int i = 1; i < VID_LAT; i++) idle();
    checkOutput("t6Clean", par_err, 1'b0);
`endif

    for (int i = 0; i < 4; i++) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
